// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), one full-subtractor step per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the two's-complement overflow output ovf.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             borrow_out_q, borrow_out_d;

    logic             x, y, d_bit, bout;
    logic [WIDTH:0]   res_ext;

    // One full-subtractor step on the current LSBs and the held borrow.
    always_comb begin
        x       = a_sr_q[0];
        y       = b_sr_q[0];
        d_bit   = x ^ y ^ borrow_q;
        bout    = (~x & y) | (~x & borrow_q) | (y & borrow_q);
        res_ext = {d_bit, res_sr_q};
    end

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d      = state_q;
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;
        res_sr_d     = res_sr_q;
        diff_d       = diff_q;
        cnt_d        = cnt_q;
        borrow_d     = borrow_q;
        borrow_out_d = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d        = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    res_sr_d = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = StShift;
                end
            end
            StShift: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = res_ext[WIDTH:1];
                borrow_d = bout;
                cnt_d    = cnt_q + CntW'(1);
                // diff is only written here so partial results never reach the output.
                if (cnt_q == LastStep) begin
                    diff_d       = res_ext[WIDTH:1];
                    borrow_out_d = bout;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d        = borrow_q ^ bout;
`endif
                    state_d      = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            res_sr_q     <= '0;
            diff_q       <= '0;
            cnt_q        <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sr_q       <= a_sr_d;
            b_sr_q       <= b_sr_d;
            res_sr_q     <= res_sr_d;
            diff_q       <= diff_d;
            cnt_q        <= cnt_d;
            borrow_q     <= borrow_d;
            borrow_out_q <= borrow_out_d;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy       = (state_q == StShift);
    assign done       = (state_q == StDone);
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule
